wb_dma_copy: RTL and testbench

- Wishbone classic initiator that copies a block of 32-bit words from a source word address to a destination word address.
- It sits on the system interconnect as a third bus master next to the CPU instruction and data buses, and targets the SRAM responder.
- It reads up to BURST words into an internal buffer, then writes them out, and repeats until the length is exhausted.
- Control is a simple start/busy/done/error strobe interface for a CSR front-end.

---
 rtl/wb_dma_pkg.sv | 20 ++
 rtl/wb_dma_buf.sv | 62 ++++++
 rtl/wb_dma_copy.sv | 200 ++++++++++++++++++++
 tb/tb_wb_dma_copy.sv | 352 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_dma_pkg.sv
// Shared definitions for the Wishbone block-copy engine: FSM encoding and
// the fixed classic-cycle bus attributes.
package wb_dma_pkg;

    localparam int ADR_W = 30;
    localparam int DAT_W = 32;

    localparam logic [2:0] CTI_CLASSIC = 3'b000;
    localparam logic [1:0] BTE_LINEAR  = 2'b00;
    localparam logic [3:0] SEL_ALL     = 4'hF;

    typedef enum logic [2:0] {
        IDLE,
        READ,
        GAP,
        WRITE,
        FIN
    } state_t;

endpackage

// File: rtl/wb_dma_buf.sv
// Word buffer between the read and write phases of a copy. Holds at most one
// chunk, so it never sees a push while full.
module wb_dma_buf
    import wb_dma_pkg::*;
#(
    parameter int  BURST = 4,
    localparam int CNT_W = $clog2(BURST + 1)
) (
    input  logic             sys_clk,
    input  logic             sys_rst,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  logic [DAT_W-1:0] wr_data,
    output logic [DAT_W-1:0] head,
    output logic [DAT_W-1:0] head_nxt,
    output logic             empty,
    output logic             full,
    output logic [CNT_W-1:0] count
);

    localparam int PTR_W = (BURST > 1) ? $clog2(BURST) : 1;

    logic [DAT_W-1:0] mem [BURST];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(BURST - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // NOTE: storage has no reset; validity is tracked by the pointers and count alone.
    always_ff @(posedge sys_clk) begin
        if (push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // NOTE: sequential state uses <= so every register sees pre-edge values.
    always_ff @(posedge sys_clk) begin
        if (sys_rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= ptr_inc(wr_ptr);
            if (pop)  rd_ptr <= ptr_inc(rd_ptr);
            if (push && !pop) begin
                count <= count + CNT_W'(1);
            end else if (pop && !push) begin
                count <= count - CNT_W'(1);
            end
        end
    end

    // head_nxt lets the write phase present the following word on the cycle after an ack
    assign head     = mem[rd_ptr];
    assign head_nxt = mem[ptr_inc(rd_ptr)];
    assign empty    = (count == '0);
    assign full     = (count == CNT_W'(BURST));

endmodule

// File: rtl/wb_dma_copy.sv
// Wishbone classic initiator copying len words from src_adr to dst_adr in
// chunks of up to BURST words, with a one-cycle bus release between phases.
module wb_dma_copy
    import wb_dma_pkg::*;
#(
    parameter int BURST = 4,
    parameter int LEN_W = 16
) (
    input  logic             sys_clk,
    input  logic             sys_rst,
    input  logic             start,
    input  logic [ADR_W-1:0] src_adr,
    input  logic [ADR_W-1:0] dst_adr,
    input  logic [LEN_W-1:0] len,
    output logic             busy,
    output logic             done,
    output logic             error,
    output logic [ADR_W-1:0] wb_adr_o,
    output logic [DAT_W-1:0] wb_dat_o,
    input  logic [DAT_W-1:0] wb_dat_i,
    output logic [3:0]       wb_sel_o,
    output logic             wb_cyc_o,
    output logic             wb_stb_o,
    output logic             wb_we_o,
    output logic [2:0]       wb_cti_o,
    output logic [1:0]       wb_bte_o,
    input  logic             wb_ack_i,
    input  logic             wb_err_i
);

    localparam int CNT_W = $clog2(BURST + 1);

    state_t           state;
    logic [ADR_W-1:0] src;
    logic [ADR_W-1:0] dst;
    logic [LEN_W-1:0] remaining;
    logic [CNT_W-1:0] chunk;

    logic [DAT_W-1:0] buf_head;
    logic [DAT_W-1:0] buf_head_nxt;
    logic             buf_empty;
    logic             buf_full;
    logic [CNT_W-1:0] buf_count;

    logic bus_ack;
    logic bus_err;
    logic buf_push;
    logic buf_pop;
    logic buf_flush;
    logic last_rd;

    function automatic logic [CNT_W-1:0] chunk_of(input logic [LEN_W-1:0] n);
        return (n >= LEN_W'(BURST)) ? CNT_W'(BURST) : CNT_W'(n);
    endfunction

    // err wins over ack; responses without a strobe are ignored
    assign bus_err   = wb_stb_o && wb_err_i;
    assign bus_ack   = wb_stb_o && wb_ack_i && !wb_err_i;
    assign buf_push  = (state == READ) && bus_ack && !buf_full;
    assign buf_pop   = (state == WRITE) && bus_ack;
    assign buf_flush = ((state == READ) || (state == WRITE)) && bus_err;
    assign last_rd   = (buf_count == chunk - CNT_W'(1));

    assign wb_cti_o = CTI_CLASSIC;
    assign wb_bte_o = BTE_LINEAR;

    wb_dma_buf #(.BURST(BURST)) u_buf (
        .sys_clk  (sys_clk),
        .sys_rst  (sys_rst),
        .push     (buf_push),
        .pop      (buf_pop),
        .flush    (buf_flush),
        .wr_data  (wb_dat_i),
        .head     (buf_head),
        .head_nxt (buf_head_nxt),
        .empty    (buf_empty),
        .full     (buf_full),
        .count    (buf_count)
    );

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state     <= IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            error     <= 1'b0;
            src       <= '0;
            dst       <= '0;
            remaining <= '0;
            chunk     <= '0;
            wb_adr_o  <= '0;
            wb_dat_o  <= '0;
            wb_sel_o  <= '0;
            wb_cyc_o  <= 1'b0;
            wb_stb_o  <= 1'b0;
            wb_we_o   <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        busy  <= 1'b1;
                        error <= 1'b0;
                        if (len != '0) begin
                            src       <= src_adr;
                            dst       <= dst_adr;
                            remaining <= len;
                            chunk     <= chunk_of(len);
                            wb_adr_o  <= src_adr;
                            wb_we_o   <= 1'b0;
                            wb_sel_o  <= SEL_ALL;
                            wb_cyc_o  <= 1'b1;
                            wb_stb_o  <= 1'b1;
                            state     <= READ;
                        end else begin
                            done  <= 1'b1;
                            state <= FIN;
                        end
                    end
                end

                READ: begin
                    if (bus_err) begin
                        wb_cyc_o <= 1'b0;
                        wb_stb_o <= 1'b0;
                        wb_sel_o <= '0;
                        error    <= 1'b1;
                        done     <= 1'b1;
                        state    <= FIN;
                    end else if (bus_ack) begin
                        src <= src + ADR_W'(1);
                        if (last_rd) begin
                            wb_cyc_o <= 1'b0;
                            wb_stb_o <= 1'b0;
                            wb_sel_o <= '0;
                            state    <= GAP;
                        end else begin
                            wb_adr_o <= src + ADR_W'(1);
                        end
                    end
                end

                GAP: begin
                    wb_cyc_o <= 1'b1;
                    wb_stb_o <= 1'b1;
                    wb_sel_o <= SEL_ALL;
                    if (!buf_empty) begin
                        wb_we_o  <= 1'b1;
                        wb_adr_o <= dst;
                        wb_dat_o <= buf_head;
                        state    <= WRITE;
                    end else begin
                        wb_we_o  <= 1'b0;
                        wb_adr_o <= src;
                        chunk    <= chunk_of(remaining);
                        state    <= READ;
                    end
                end

                WRITE: begin
                    if (bus_err) begin
                        wb_cyc_o <= 1'b0;
                        wb_stb_o <= 1'b0;
                        wb_we_o  <= 1'b0;
                        wb_sel_o <= '0;
                        error    <= 1'b1;
                        done     <= 1'b1;
                        state    <= FIN;
                    end else if (bus_ack) begin
                        dst       <= dst + ADR_W'(1);
                        remaining <= remaining - LEN_W'(1);
                        if (buf_count == CNT_W'(1)) begin
                            wb_cyc_o <= 1'b0;
                            wb_stb_o <= 1'b0;
                            wb_we_o  <= 1'b0;
                            wb_sel_o <= '0;
                            if (remaining == LEN_W'(1)) begin
                                done  <= 1'b1;
                                state <= FIN;
                            end else begin
                                state <= GAP;
                            end
                        end else begin
                            wb_adr_o <= dst + ADR_W'(1);
                            wb_dat_o <= buf_head_nxt;
                        end
                    end
                end

                FIN: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_wb_dma_copy.sv
// Self-checking bench for wb_dma_copy: a behavioural SRAM responder, an
// expectation queue per output stream and a monitor that drains them.
module tb_wb_dma_copy;

    logic        sys_clk = 1'b0;
    logic        sys_rst;
    logic        start;
    logic [29:0] src_adr;
    logic [29:0] dst_adr;
    logic [15:0] len;
    logic        busy;
    logic        done;
    logic        error;
    logic [29:0] wb_adr_o;
    logic [31:0] wb_dat_o;
    logic [31:0] wb_dat_i;
    logic [3:0]  wb_sel_o;
    logic        wb_cyc_o;
    logic        wb_stb_o;
    logic        wb_we_o;
    logic [2:0]  wb_cti_o;
    logic [1:0]  wb_bte_o;
    logic        wb_ack_i;
    logic        wb_err_i;

    always #5 sys_clk = ~sys_clk;

    wb_dma_copy #(.BURST(4), .LEN_W(16)) dut (
        .sys_clk  (sys_clk),
        .sys_rst  (sys_rst),
        .start    (start),
        .src_adr  (src_adr),
        .dst_adr  (dst_adr),
        .len      (len),
        .busy     (busy),
        .done     (done),
        .error    (error),
        .wb_adr_o (wb_adr_o),
        .wb_dat_o (wb_dat_o),
        .wb_dat_i (wb_dat_i),
        .wb_sel_o (wb_sel_o),
        .wb_cyc_o (wb_cyc_o),
        .wb_stb_o (wb_stb_o),
        .wb_we_o  (wb_we_o),
        .wb_cti_o (wb_cti_o),
        .wb_bte_o (wb_bte_o),
        .wb_ack_i (wb_ack_i),
        .wb_err_i (wb_err_i)
    );

    typedef struct {
        logic [29:0] adr;
        logic [31:0] dat;
    } wr_t;

    logic [31:0] mem [logic [29:0]];
    logic [29:0] exp_rd [$];
    wr_t         exp_wr [$];
    logic        exp_done [$];

    int checks = 0;
    int errors = 0;

    // responder knobs and observation counters
    bit rand_ack    = 1'b0;
    int err_at_read = -1;
    int rd_issued   = 0;
    int ack_cnt     = 0;
    int gap_cnt     = 0;
    int cyc_cnt     = 0;
    int wr_cycles   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual %0h required %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] pat(input logic [29:0] a);
        return 32'hC0DE_0000 ^ {2'b00, a};
    endfunction

    task automatic expect_copy(input logic [29:0] s, input logic [29:0] d, input int n);
        for (int i = 0; i < n; i++) begin
            logic [29:0] sa;
            logic [29:0] da;
            sa = s + 30'(i);
            da = d + 30'(i);
            exp_rd.push_back(sa);
            exp_wr.push_back('{da, mem[sa]});
        end
        exp_done.push_back(1'b0);
    endtask

    // start is high for one cycle; returns at the falling edge of the cycle after acceptance
    task automatic pulse_start(input logic [29:0] s, input logic [29:0] d, input logic [15:0] n);
        @(negedge sys_clk);
        src_adr = s;
        dst_adr = d;
        len     = n;
        start   = 1'b1;
        @(negedge sys_clk);
        start   = 1'b0;
    endtask

    task automatic wait_idle(input int max_cyc);
        int n;
        n = 0;
        while (busy && n < max_cyc) begin
            @(negedge sys_clk);
            n++;
        end
        check("idle_timeout", 64'(busy), 64'(0));
    endtask

    // SRAM responder: decides at the falling edge, drives just after the rising edge
    initial begin : responder
        logic        nxt_ack;
        logic        nxt_err;
        logic [31:0] nxt_dat;
        wb_ack_i = 1'b0;
        wb_err_i = 1'b0;
        wb_dat_i = '0;
        forever begin
            @(negedge sys_clk);
            if (wb_cyc_o && wb_stb_o && wb_we_o && wb_ack_i && !wb_err_i) begin
                mem[wb_adr_o] = wb_dat_o;
            end
            nxt_ack = 1'b0;
            nxt_err = 1'b0;
            nxt_dat = '0;
            if (wb_cyc_o && wb_stb_o && !wb_ack_i && !wb_err_i &&
                (!rand_ack || $urandom_range(1, 0) == 1)) begin
                if (!wb_we_o && rd_issued == err_at_read) nxt_err = 1'b1;
                else nxt_ack = 1'b1;
                if (!wb_we_o) rd_issued++;
                if (mem.exists(wb_adr_o)) nxt_dat = mem[wb_adr_o];
            end
            @(posedge sys_clk);
            #1;
            wb_ack_i = nxt_ack;
            wb_err_i = nxt_err;
            wb_dat_i = nxt_dat;
        end
    end

    initial begin : monitor
        logic        prev_req;
        logic [29:0] prev_adr;
        logic [29:0] a;
        logic        e;
        wr_t         w;
        prev_req = 1'b0;
        prev_adr = '0;
        forever begin
            @(negedge sys_clk);
            if (prev_req && !sys_rst) begin
                check("stb_held", 64'(wb_stb_o), 64'(1));
                check("adr_held", 64'(wb_adr_o), 64'(prev_adr));
            end
            if (wb_stb_o) begin
                check("sel_all", 64'(wb_sel_o), 64'(4'hF));
                check("cti_bte", 64'({wb_cti_o, wb_bte_o}), 64'(0));
            end
            if (wb_cyc_o && wb_stb_o && wb_ack_i && !wb_err_i) begin
                ack_cnt++;
                if (wb_we_o) begin
                    check("wr_expected", 64'(exp_wr.size() != 0), 64'(1));
                    if (exp_wr.size() != 0) begin
                        w = exp_wr.pop_front();
                        check("wr_adr", 64'(wb_adr_o), 64'(w.adr));
                        check("wr_dat", 64'(wb_dat_o), 64'(w.dat));
                    end
                end else begin
                    check("rd_expected", 64'(exp_rd.size() != 0), 64'(1));
                    if (exp_rd.size() != 0) begin
                        a = exp_rd.pop_front();
                        check("rd_adr", 64'(wb_adr_o), 64'(a));
                    end
                end
            end
            if (done) begin
                check("done_expected", 64'(exp_done.size() != 0), 64'(1));
                if (exp_done.size() != 0) begin
                    e = exp_done.pop_front();
                    check("done_error", 64'(error), 64'(e));
                end
            end
            if (busy && !wb_cyc_o) gap_cnt++;
            if (wb_cyc_o) cyc_cnt++;
            if (wb_cyc_o && wb_stb_o && wb_we_o) wr_cycles++;
            prev_req = wb_cyc_o && wb_stb_o && !wb_ack_i && !wb_err_i && !sys_rst;
            prev_adr = wb_adr_o;
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin : stimulus
        int n;
        sys_rst = 1'b1;
        start   = 1'b0;
        src_adr = '0;
        dst_adr = '0;
        len     = '0;
        repeat (3) @(negedge sys_clk);
        check("rst_bus", 64'({wb_cyc_o, wb_stb_o, wb_we_o, wb_sel_o}), 64'(0));
        check("rst_adr_dat", 64'({wb_adr_o, wb_dat_o}), 64'(0));
        check("rst_ctrl", 64'({busy, done, error}), 64'(0));
        sys_rst = 1'b0;

        // 1: single word, cycle-exact latency
        mem[30'h100] = 32'hDEADBEEF;
        mem[30'h200] = 32'h0;
        expect_copy(30'h100, 30'h200, 1);
        pulse_start(30'h100, 30'h200, 16'd1);
        check("t1_rd_stb", 64'(wb_stb_o && wb_cyc_o && !wb_we_o), 64'(1));
        check("t1_rd_adr", 64'(wb_adr_o), 64'(30'h100));
        @(negedge sys_clk);
        check("t1_rd_ack", 64'(wb_ack_i), 64'(1));
        @(negedge sys_clk);
        check("t1_gap", 64'({busy, wb_cyc_o}), 64'(2'b10));
        @(negedge sys_clk);
        check("t1_wr_stb", 64'(wb_stb_o && wb_we_o), 64'(1));
        check("t1_wr_adr", 64'(wb_adr_o), 64'(30'h200));
        check("t1_wr_dat", 64'(wb_dat_o), 64'(32'hDEADBEEF));
        @(negedge sys_clk);
        check("t1_wr_ack", 64'(wb_ack_i), 64'(1));
        @(negedge sys_clk);
        check("t1_done", 64'({done, busy}), 64'(2'b11));
        @(negedge sys_clk);
        check("t1_after", 64'({done, busy}), 64'(0));
        check("t1_mem", 64'(mem[30'h200]), 64'(32'hDEADBEEF));
        check("t1_error", 64'(error), 64'(0));

        // 2: ten words in chunks of 4, 4, 2
        for (int i = 0; i < 10; i++) begin
            mem[30'(i)]        = pat(30'(i));
            mem[30'h40 + 30'(i)] = 32'h0;
        end
        ack_cnt = 0;
        gap_cnt = 0;
        expect_copy(30'h0, 30'h40, 10);
        pulse_start(30'h0, 30'h40, 16'd10);
        wait_idle(300);
        check("t2_acks", 64'(ack_cnt), 64'(20));
        check("t2_idle_cyc", 64'(gap_cnt), 64'(6));
        for (int i = 0; i < 10; i++) begin
            check("t2_mem", 64'(mem[30'h40 + 30'(i)]), 64'(pat(30'(i))));
        end

        // 3: zero length
        cyc_cnt = 0;
        exp_done.push_back(1'b0);
        pulse_start(30'h10, 30'h20, 16'd0);
        check("t3_done", 64'({done, busy}), 64'(2'b11));
        @(negedge sys_clk);
        check("t3_after", 64'({done, busy}), 64'(0));
        @(negedge sys_clk);
        check("t3_no_cyc", 64'(cyc_cnt), 64'(0));

        // 4: error on the third read, then a clean copy clears the flag
        for (int i = 0; i < 8; i++) mem[30'h300 + 30'(i)] = pat(30'h300 + 30'(i));
        rd_issued   = 0;
        err_at_read = 2;
        wr_cycles   = 0;
        exp_rd.push_back(30'h300);
        exp_rd.push_back(30'h301);
        exp_done.push_back(1'b1);
        pulse_start(30'h300, 30'h380, 16'd8);
        n = 0;
        while (!wb_err_i && n < 50) begin
            @(negedge sys_clk);
            n++;
        end
        check("t4_err_seen", 64'(wb_err_i), 64'(1));
        @(negedge sys_clk);
        check("t4_cyc_drop", 64'(wb_cyc_o), 64'(0));
        check("t4_done", 64'({done, error}), 64'(2'b11));
        wait_idle(20);
        check("t4_no_write", 64'(wr_cycles), 64'(0));
        check("t4_sticky", 64'(error), 64'(1));
        err_at_read = -1;
        mem[30'h310] = 32'h1357_9BDF;
        expect_copy(30'h310, 30'h390, 1);
        pulse_start(30'h310, 30'h390, 16'd1);
        check("t4_err_clr", 64'(error), 64'(0));
        wait_idle(50);
        check("t4_mem", 64'(mem[30'h390]), 64'(32'h1357_9BDF));

        // 5: random ack timing, second start while busy is ignored
        for (int i = 0; i < 6; i++) mem[30'h500 + 30'(i)] = pat(30'h500 + 30'(i));
        mem[30'hA00] = 32'h0;
        rand_ack = 1'b1;
        expect_copy(30'h500, 30'h600, 6);
        pulse_start(30'h500, 30'h600, 16'd6);
        repeat (3) @(negedge sys_clk);
        pulse_start(30'h900, 30'hA00, 16'd3);
        wait_idle(1000);
        rand_ack = 1'b0;
        for (int i = 0; i < 6; i++) begin
            check("t5_mem", 64'(mem[30'h600 + 30'(i)]), 64'(pat(30'h500 + 30'(i))));
        end
        check("t5_ignored", 64'(mem[30'hA00]), 64'(0));

        // 6: reset during a write phase, then a copy across the address wrap
        for (int i = 0; i < 4; i++) mem[30'h700 + 30'(i)] = pat(30'h700 + 30'(i));
        expect_copy(30'h700, 30'h780, 4);
        pulse_start(30'h700, 30'h780, 16'd4);
        n = 0;
        while (!(wb_stb_o && wb_we_o) && n < 100) begin
            @(negedge sys_clk);
            n++;
        end
        check("t6_in_write", 64'(wb_stb_o && wb_we_o), 64'(1));
        sys_rst = 1'b1;
        @(negedge sys_clk);
        check("t6_rst_bus", 64'({wb_cyc_o, wb_stb_o, wb_we_o, wb_sel_o}), 64'(0));
        check("t6_rst_adr_dat", 64'({wb_adr_o, wb_dat_o}), 64'(0));
        check("t6_rst_ctrl", 64'({busy, done, error}), 64'(0));
        exp_rd.delete();
        exp_wr.delete();
        exp_done.delete();
        @(negedge sys_clk);
        sys_rst = 1'b0;
        repeat (3) @(negedge sys_clk);
        mem[30'h3FFF_FFFF] = 32'h0BAD_F00D;
        mem[30'h0]         = 32'h1234_5678;
        mem[30'h800]       = 32'h0;
        mem[30'h801]       = 32'h0;
        expect_copy(30'h3FFF_FFFF, 30'h800, 2);
        pulse_start(30'h3FFF_FFFF, 30'h800, 16'd2);
        wait_idle(100);
        check("t6_mem0", 64'(mem[30'h800]), 64'(32'h0BAD_F00D));
        check("t6_mem1", 64'(mem[30'h801]), 64'(32'h1234_5678));
        check("t6_error", 64'(error), 64'(0));

        repeat (3) @(negedge sys_clk);
        check("left_rd", 64'(exp_rd.size()), 64'(0));
        check("left_wr", 64'(exp_wr.size()), 64'(0));
        check("left_done", 64'(exp_done.size()), 64'(0));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
